// File: rtl/piradip_axil_regbank_bridge.sv
// AXI4-Lite subordinate bridging onto the register-server port, with decoupled AW/W holding,
// configurable read-server latency and SLVERR decode of out-of-range register numbers.
module piradip_axil_regbank_bridge #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 16,
   parameter int READ_LATENCY  = 1,
   parameter int ERR_CNT_WIDTH = 16,
   localparam int ADDR_LSB     = $clog2(DATA_WIDTH / 8),
   localparam int REG_BITS     = ADDR_WIDTH - ADDR_LSB,
   localparam int STRB_W       = DATA_WIDTH / 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ADDR_WIDTH-1:0]    s_awaddr,
   input  logic [2:0]               s_awprot,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   input  logic [DATA_WIDTH-1:0]    s_wdata,
   input  logic [STRB_W-1:0]        s_wstrb,
   input  logic                     s_wvalid,
   output logic                     s_wready,
   output logic [1:0]               s_bresp,
   output logic                     s_bvalid,
   input  logic                     s_bready,
   input  logic [ADDR_WIDTH-1:0]    s_araddr,
   input  logic [2:0]               s_arprot,
   input  logic                     s_arvalid,
   output logic                     s_arready,
   output logic [DATA_WIDTH-1:0]    s_rdata,
   output logic [1:0]               s_rresp,
   output logic                     s_rvalid,
   input  logic                     s_rready,
   output logic                     wren,
   output logic [REG_BITS-1:0]      wreg_no,
   output logic [DATA_WIDTH-1:0]    wreg_data,
   output logic [STRB_W-1:0]        wstrb,
   output logic                     rden,
   output logic [REG_BITS-1:0]      rreg_no,
   input  logic [DATA_WIDTH-1:0]    rreg_data,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                     r_aw_full, r_w_full, r_ar_full;
   logic                     r_bvalid, r_rvalid, r_rd_busy;
   logic [REG_BITS-1:0]      r_aw_regno, r_ar_regno;
   logic [DATA_WIDTH-1:0]    r_wdata, r_rdata;
   logic [STRB_W-1:0]        r_wstrb;
   logic [1:0]               r_bresp, r_rresp;
   logic [2:0]               r_rd_cnt;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

   logic       w_aw_hs, w_w_hs, w_ar_hs;
   logic       w_wr_issue, w_rd_issue, w_wr_ok, w_rd_ok, w_rd_sample;
   logic [1:0] w_err_inc;
   logic       w_unused;

   function automatic logic in_range(input logic [REG_BITS-1:0] regno);
      return 32'(regno) < 32'(NUM_REGS);
   endfunction

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(input logic [ERR_CNT_WIDTH-1:0] cnt,
                                                        input logic [1:0] inc);
      logic [ERR_CNT_WIDTH:0] sum;
      sum = {1'b0, cnt} + (ERR_CNT_WIDTH + 1)'(inc);
      return sum[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}} : sum[ERR_CNT_WIDTH-1:0];
   endfunction

   assign w_unused = ^{s_awprot, s_arprot, s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};

   assign s_awready = ~r_aw_full & ~areset;
   assign s_wready  = ~r_w_full & ~areset;
   assign s_arready = ~r_ar_full & ~areset;

   assign w_aw_hs = s_awvalid & s_awready;
   assign w_w_hs  = s_wvalid & s_wready;
   assign w_ar_hs = s_arvalid & s_arready;

   // Issue gating with areset keeps a held transaction from leaking a strobe during reset.
   assign w_wr_ok     = in_range(r_aw_regno);
   assign w_rd_ok     = in_range(r_ar_regno);
   assign w_wr_issue  = r_aw_full & r_w_full & ~r_bvalid & ~areset;
   assign w_rd_issue  = r_ar_full & ~r_rd_busy & ~r_rvalid & ~areset;
   assign w_rd_sample = r_rd_busy & (r_rd_cnt == 3'(READ_LATENCY));
   assign w_err_inc   = 2'(w_wr_issue & ~w_wr_ok) + 2'(w_rd_issue & ~w_rd_ok);

   assign wren      = w_wr_issue & w_wr_ok;
   assign wreg_no   = r_aw_regno;
   assign wreg_data = r_wdata;
   assign wstrb     = r_wstrb;
   assign rden      = w_rd_issue & w_rd_ok;
   assign rreg_no   = r_ar_regno;

   assign s_bvalid  = r_bvalid;
   assign s_bresp   = r_bresp;
   assign s_rvalid  = r_rvalid;
   assign s_rresp   = r_rresp;
   assign s_rdata   = r_rdata;
   assign err_count = r_err_cnt;

   // Holding-register payloads: only meaningful while their full flag is set.
   always_ff @(posedge aclk) begin
      if (w_aw_hs) r_aw_regno <= s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      if (w_w_hs) begin
         r_wdata <= s_wdata;
         r_wstrb <= s_wstrb;
      end
      if (w_ar_hs) r_ar_regno <= s_araddr[ADDR_WIDTH-1:ADDR_LSB];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_ar_full <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
         r_rd_busy <= 1'b0;
         r_rd_cnt  <= 3'd0;
         r_err_cnt <= '0;
      end else begin
         if (w_aw_hs)         r_aw_full <= 1'b1;
         else if (w_wr_issue) r_aw_full <= 1'b0;
         if (w_w_hs)          r_w_full  <= 1'b1;
         else if (w_wr_issue) r_w_full  <= 1'b0;
         if (w_ar_hs)         r_ar_full <= 1'b1;
         else if (w_rd_issue) r_ar_full <= 1'b0;

         if (w_wr_issue) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (r_bvalid && s_bready) begin
            r_bvalid <= 1'b0;
         end

         // Read pipeline: r_rd_cnt counts cycles since rden, sampling when it reaches READ_LATENCY.
         if (w_rd_issue) begin
            if (!w_rd_ok) begin
               r_rvalid <= 1'b1;
               r_rdata  <= '0;
               r_rresp  <= RESP_SLVERR;
            end else if (READ_LATENCY == 0) begin
               r_rvalid <= 1'b1;
               r_rdata  <= rreg_data;
               r_rresp  <= RESP_OKAY;
            end else begin
               r_rd_busy <= 1'b1;
               r_rd_cnt  <= 3'd1;
            end
         end else if (w_rd_sample) begin
            r_rd_busy <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= rreg_data;
            r_rresp   <= RESP_OKAY;
         end else begin
            if (r_rd_busy) r_rd_cnt <= r_rd_cnt + 3'd1;
            if (r_rvalid && s_rready) r_rvalid <= 1'b0;
         end

         if (w_err_inc != 2'd0) r_err_cnt <= sat_add(r_err_cnt, w_err_inc);
      end
   end

endmodule

// File: tb/tb_piradip_axil_regbank_bridge.sv
// Scoreboard bench: two bridges (read latency 3 with a 2-bit error counter, and latency 0) share
// one AXI stimulus stream; per-instance monitors consume shared expected-response lists.
module tb_piradip_axil_regbank_bridge;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [7:0]  s_awaddr = '0, s_araddr = '0;
   logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_bready = 1'b1, s_rready = 1'b1;

   logic        awready [2], wready [2], arready [2], bvalid [2], rvalid [2];
   logic [1:0]  bresp [2], rresp [2];
   logic [31:0] rdata [2];
   logic        wren_o [2], rden_o [2];
   logic [5:0]  wreg_no_o [2], rreg_no_o [2];
   logic [31:0] wreg_data_o [2], rreg_data_i [2];
   logic [3:0]  wstrb_o [2];
   logic [1:0]  err_a;
   logic [15:0] err_b;

   typedef struct { logic ok; logic [5:0] regno; logic [31:0] data; logic [3:0] strb; } wexp_t;
   typedef struct { logic ok; logic [5:0] regno; logic [31:0] data; logic [1:0] resp; } rexp_t;
   wexp_t      wlist[$];
   logic [1:0] blist[$];
   rexp_t      rlist[$];
   int widx [2] = '{0, 0};
   int bidx [2] = '{0, 0};
   int ridx [2] = '{0, 0};
   int wren_cyc [2] = '{0, 0};
   int rden_cyc [2] = '{0, 0};
   bit rden_seen [2] = '{0, 0};
   bit bv_pend [2] = '{0, 0};
   bit bv_prev [2] = '{0, 0};
   logic [1:0] bresp_prev [2];

   int n_cmp = 0, n_err = 0, cyc = 0;

   logic [31:0] mem [2][16];
   logic [2:0]  p_vld = '0;
   logic [3:0]  p_no [3];

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   piradip_axil_regbank_bridge #(.READ_LATENCY(3), .ERR_CNT_WIDTH(2)) u_dut_l3 (
      .aclk(aclk), .areset(areset),
      .s_awaddr(s_awaddr), .s_awprot(3'b000), .s_awvalid(s_awvalid), .s_awready(awready[0]),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(wready[0]),
      .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(3'b000), .s_arvalid(s_arvalid), .s_arready(arready[0]),
      .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(s_rready),
      .wren(wren_o[0]), .wreg_no(wreg_no_o[0]), .wreg_data(wreg_data_o[0]), .wstrb(wstrb_o[0]),
      .rden(rden_o[0]), .rreg_no(rreg_no_o[0]), .rreg_data(rreg_data_i[0]), .err_count(err_a));

   piradip_axil_regbank_bridge #(.READ_LATENCY(0)) u_dut_l0 (
      .aclk(aclk), .areset(areset),
      .s_awaddr(s_awaddr), .s_awprot(3'b000), .s_awvalid(s_awvalid), .s_awready(awready[1]),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(wready[1]),
      .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(3'b000), .s_arvalid(s_arvalid), .s_arready(arready[1]),
      .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(s_rready),
      .wren(wren_o[1]), .wreg_no(wreg_no_o[1]), .wreg_data(wreg_data_o[1]), .wstrb(wstrb_o[1]),
      .rden(rden_o[1]), .rreg_no(rreg_no_o[1]), .rreg_data(rreg_data_i[1]), .err_count(err_b));

   // Register-server models: byte-strobed storage, data valid 3 cycles (inst 0) or 0 cycles (inst 1) after rden.
   initial for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mem[d][i] = '0;

   always @(posedge aclk) begin
      for (int d = 0; d < 2; d++)
         if (wren_o[d])
            for (int b = 0; b < 4; b++)
               if (wstrb_o[d][b]) mem[d][wreg_no_o[d][3:0]][8*b +: 8] <= wreg_data_o[d][8*b +: 8];
      p_vld   <= {p_vld[1:0], rden_o[0]};
      p_no[0] <= rreg_no_o[0][3:0];
      p_no[1] <= p_no[0];
      p_no[2] <= p_no[1];
   end

   assign rreg_data_i[0] = p_vld[2] ? mem[0][p_no[2]] : 32'hBADC0DE0;
   assign rreg_data_i[1] = rden_o[1] ? mem[1][rreg_no_o[1][3:0]] : 32'hBADC0DE1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
   endtask

   // Monitor: checks every strobe and response of both instances against the expected lists.
   always @(negedge aclk) begin
      for (int d = 0; d < 2; d++) begin
         if (areset) begin
            bv_pend[d]   = 1'b0;
            bv_prev[d]   = 1'b0;
            rden_seen[d] = 1'b0;
         end else begin
            if (wren_o[d]) begin
               if (widx[d] >= wlist.size()) flag($sformatf("unexpected_wren inst%0d regno %0d", d, wreg_no_o[d]));
               else begin
                  chk($sformatf("wreg_no%0d", d), 64'(wreg_no_o[d]), 64'(wlist[widx[d]].regno));
                  chk($sformatf("wreg_data%0d", d), 64'(wreg_data_o[d]), 64'(wlist[widx[d]].data));
                  chk($sformatf("wstrb%0d", d), 64'(wstrb_o[d]), 64'(wlist[widx[d]].strb));
                  chk($sformatf("wren_while_bvalid%0d", d), 64'(bvalid[d]), 64'(0));
                  widx[d]++;
                  wren_cyc[d] = cyc;
               end
            end
            if (bv_pend[d]) begin
               chk($sformatf("b_hold_valid%0d", d), 64'(bvalid[d]), 64'(1));
               chk($sformatf("b_hold_resp%0d", d), 64'(bresp[d]), 64'(bresp_prev[d]));
            end
            if (bvalid[d] && !bv_prev[d] && bidx[d] < blist.size() && blist[bidx[d]] == 2'b00)
               chk($sformatf("b_latency%0d", d), 64'(cyc - wren_cyc[d]), 64'(1));
            if (bvalid[d] && s_bready) begin
               if (bidx[d] >= blist.size()) flag($sformatf("unexpected_bvalid inst%0d", d));
               else begin
                  chk($sformatf("bresp%0d", d), 64'(bresp[d]), 64'(blist[bidx[d]]));
                  bidx[d]++;
               end
            end
            bv_pend[d]    = bvalid[d] && !s_bready;
            bv_prev[d]    = bvalid[d];
            bresp_prev[d] = bresp[d];

            if (rden_o[d]) begin
               if (ridx[d] >= rlist.size() || !rlist[ridx[d]].ok || rden_seen[d])
                  flag($sformatf("unexpected_rden inst%0d regno %0d", d, rreg_no_o[d]));
               else begin
                  chk($sformatf("rreg_no%0d", d), 64'(rreg_no_o[d]), 64'(rlist[ridx[d]].regno));
                  rden_seen[d] = 1'b1;
                  rden_cyc[d]  = cyc;
               end
            end
            if (rvalid[d] && s_rready) begin
               if (ridx[d] >= rlist.size()) flag($sformatf("unexpected_rvalid inst%0d", d));
               else begin
                  chk($sformatf("rdata%0d", d), 64'(rdata[d]), 64'(rlist[ridx[d]].data));
                  chk($sformatf("rresp%0d", d), 64'(rresp[d]), 64'(rlist[ridx[d]].resp));
                  if (rlist[ridx[d]].ok) begin
                     chk($sformatf("r_saw_rden%0d", d), 64'(rden_seen[d]), 64'(1));
                     chk($sformatf("r_latency%0d", d), 64'(cyc - rden_cyc[d]), 64'(d == 0 ? 4 : 1));
                  end
                  ridx[d]++;
                  rden_seen[d] = 1'b0;
               end
            end
         end
      end
   end

   task automatic send_aw(input logic [7:0] a);
      int n = 0;
      s_awaddr = a; s_awvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!(awready[0] && awready[1]) && n < 200);
      if (!(awready[0] && awready[1])) flag("aw_handshake_timeout");
      @(posedge aclk); #1 s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] dat, input logic [3:0] st);
      int n = 0;
      s_wdata = dat; s_wstrb = st; s_wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!(wready[0] && wready[1]) && n < 200);
      if (!(wready[0] && wready[1])) flag("w_handshake_timeout");
      @(posedge aclk); #1 s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [7:0] a);
      int n = 0;
      s_araddr = a; s_arvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!(arready[0] && arready[1]) && n < 200);
      if (!(arready[0] && arready[1])) flag("ar_handshake_timeout");
      @(posedge aclk); #1 s_arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] st,
                           input int awd, input int wd, input logic ok, input logic [5:0] regno);
      wexp_t e;
      e.ok = ok; e.regno = regno; e.data = dat; e.strb = st;
      if (ok) wlist.push_back(e);
      blist.push_back(ok ? 2'b00 : 2'b10);
      fork
         begin
            if (awd > 0) begin repeat (awd) @(posedge aclk); #1; end
            send_aw(a);
         end
         begin
            if (wd > 0) begin repeat (wd) @(posedge aclk); #1; end
            send_w(dat, st);
         end
      join
   endtask

   task automatic do_read(input logic [7:0] a, input logic ok, input logic [5:0] regno,
                          input logic [31:0] dat, input logic [1:0] resp);
      rexp_t e;
      e.ok = ok; e.regno = regno; e.data = dat; e.resp = resp;
      rlist.push_back(e);
      send_ar(a);
   endtask

   function automatic bit all_done();
      for (int d = 0; d < 2; d++)
         if (widx[d] != wlist.size() || bidx[d] != blist.size() || ridx[d] != rlist.size()) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done();
      int n = 0;
      while (!all_done() && n < 300) begin @(negedge aclk); n++; end
      if (!all_done()) flag("response_timeout");
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic chk_readies(input string tag, input logic exp);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_awready%0d", tag, d), 64'(awready[d]), 64'(exp));
         chk($sformatf("%s_wready%0d", tag, d), 64'(wready[d]), 64'(exp));
         chk($sformatf("%s_arready%0d", tag, d), 64'(arready[d]), 64'(exp));
      end
   endtask

   initial begin
      int n;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk_readies("rst", 1'b0);
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      chk_readies("post_rst", 1'b1);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_bvalid%0d", d), 64'(bvalid[d]), 64'(0));
         chk($sformatf("rst_rvalid%0d", d), 64'(rvalid[d]), 64'(0));
      end
      chk("rst_err_a", 64'(err_a), 64'(0));
      chk("rst_err_b", 64'(err_b), 64'(0));
      @(posedge aclk); #1;

      do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 5, 1'b1, 6'd2);
      wait_done();

      // Stall B for several cycles with a second write queued behind it.
      s_bready = 1'b0;
      do_write(8'h0C, 32'hA5A50001, 4'hF, 3, 0, 1'b1, 6'd3);
      do_write(8'h10, 32'h00001111, 4'hF, 0, 0, 1'b1, 6'd4);
      n = 0;
      while (!(bvalid[0] && bvalid[1]) && n < 50) begin @(negedge aclk); n++; end
      if (!(bvalid[0] && bvalid[1])) flag("bvalid_timeout");
      repeat (4) @(posedge aclk);
      chk("hold_no_issue0", 64'(widx[0]), 64'(2));
      chk("hold_no_issue1", 64'(widx[1]), 64'(2));
      #1 s_bready = 1'b1;
      wait_done();

      do_write(8'h14, 32'h12345678, 4'hF, 0, 0, 1'b1, 6'd5);
      wait_done();
      do_read(8'h14, 1'b1, 6'd5, 32'h12345678, 2'b00);
      wait_done();
      do_write(8'h08, 32'hFFFFFFFF, 4'h3, 1, 0, 1'b1, 6'd2);
      wait_done();
      do_read(8'h08, 1'b1, 6'd2, 32'hDEADFFFF, 2'b00);
      wait_done();
      do_read(8'h13, 1'b1, 6'd4, 32'h00001111, 2'b00);
      wait_done();

      do_read(8'h40, 1'b0, 6'd16, 32'h0, 2'b10);
      wait_done();
      chk("err_a_1", 64'(err_a), 64'(1));
      chk("err_b_1", 64'(err_b), 64'(1));
      do_write(8'h44, 32'h0000CAFE, 4'hF, 0, 0, 1'b0, 6'd17);
      wait_done();
      chk("err_a_2", 64'(err_a), 64'(2));
      chk("err_b_2", 64'(err_b), 64'(2));

      do_write(8'h04, 32'h11111111, 4'hF, 0, 0, 1'b1, 6'd1);
      wait_done();
      fork
         do_write(8'h04, 32'h11111111, 4'hF, 0, 0, 1'b1, 6'd1);
         do_read(8'h04, 1'b1, 6'd1, 32'h11111111, 2'b00);
      join
      wait_done();

      // Read and write SLVERR issue in the same cycle: counter steps by 2.
      fork
         do_write(8'h48, 32'h0, 4'hF, 0, 0, 1'b0, 6'd18);
         do_read(8'h4C, 1'b0, 6'd19, 32'h0, 2'b10);
      join
      wait_done();
      chk("err_a_sat4", 64'(err_a), 64'(3));
      chk("err_b_4", 64'(err_b), 64'(4));
      do_read(8'hFC, 1'b0, 6'd63, 32'h0, 2'b10);
      wait_done();
      chk("err_a_sat5", 64'(err_a), 64'(3));
      chk("err_b_5", 64'(err_b), 64'(5));

      // AW captured, reset the following cycle with W still pending.
      send_aw(8'h0C);
      areset = 1'b1;
      @(negedge aclk);
      chk_readies("drop_rst", 1'b0);
      @(posedge aclk); #1 areset = 1'b0;
      @(negedge aclk);
      chk_readies("drop_post", 1'b1);
      chk("drop_err_a", 64'(err_a), 64'(0));
      chk("drop_err_b", 64'(err_b), 64'(0));
      @(posedge aclk); #1;
      send_w(32'h00000055, 4'hF);
      repeat (10) @(posedge aclk);
      @(negedge aclk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("drop_bvalid%0d", d), 64'(bvalid[d]), 64'(0));
         chk($sformatf("drain_w%0d", d), 64'(widx[d]), 64'(wlist.size()));
         chk($sformatf("drain_b%0d", d), 64'(bidx[d]), 64'(blist.size()));
         chk($sformatf("drain_r%0d", d), 64'(ridx[d]), 64'(rlist.size()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
